// File: rtl/fetch_pkg.sv
// Shared types and helpers for the decoupled instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam int unsigned FETCH_ADDR_WIDTH = 32;

  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0] pc;
    logic [31:0]                 instr;
  } fetch_entry_t;

  // Width able to hold the values 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of fetched (pc, instr) entries with synchronous flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t,
  localparam int unsigned CW     = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch.sv
// Latency-tolerant fetch stage: in-order imem requests, credit-limited
// prefetch queue, and redirect flush that drops in-flight responses.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_f,
  input  logic                  pc_src_e,
  input  logic [ADDR_WIDTH-1:0] pc_target_e,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_data,
  output logic                  valid_f,
  output logic [31:0]           instruction_f,
  output logic [ADDR_WIDTH-1:0] pc_f,
  output logic [ADDR_WIDTH-1:0] pc_plus_4_f
);

  localparam int unsigned CW = count_width(QUEUE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INSTR_BYTES);

  // Same layout as fetch_entry_t, sized to this instance's address width.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           instr;
  } entry_t;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] rsp_pc;
  logic [CW-1:0]         live;
  logic [CW-1:0]         drop;
  logic [CW-1:0]         q_count;
  entry_t                q_head;
  entry_t                q_push_data;

  logic [CW:0]           occ_queue;
  logic [CW:0]           occ_mem;
  logic                  req_fire;
  logic                  rsp_live;
  logic                  rsp_stale;
  logic                  deq;
  logic [ADDR_WIDTH-1:0] target_aligned;

  always_comb begin
    occ_queue      = {1'b0, q_count} + {1'b0, live};
    occ_mem        = {1'b0, live} + {1'b0, drop};
    imem_req_valid = !reset && !pc_src_e
                     && (occ_queue < (CW+1)'(QUEUE_DEPTH))
                     && (occ_mem   < (CW+1)'(QUEUE_DEPTH));
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_live       = imem_rsp_valid && !pc_src_e && (drop == '0);
    rsp_stale      = imem_rsp_valid && !pc_src_e && (drop != '0);
    target_aligned = {pc_target_e[ADDR_WIDTH-1:2], 2'b00};
    q_push_data    = '{pc: rsp_pc, instr: imem_rsp_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      live     <= '0;
      drop     <= '0;
    end else if (pc_src_e) begin
      // Any response this cycle retires one outstanding request; the rest go stale.
      fetch_pc <= target_aligned;
      rsp_pc   <= target_aligned;
      live     <= '0;
      drop     <= drop + live - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + STEP;
      if (rsp_live) rsp_pc   <= rsp_pc + STEP;
      live <= live + CW'(req_fire) - CW'(rsp_live);
      drop <= drop - CW'(rsp_stale);
    end
  end

  fetch_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (pc_src_e),
    .push      (rsp_live),
    .push_data (q_push_data),
    .pop       (deq),
    .head      (q_head),
    .count     (q_count)
  );

  always_comb begin
    valid_f       = (q_count != '0);
    deq           = valid_f && !stall_f && !pc_src_e;
    instruction_f = valid_f ? q_head.instr : '0;
    pc_f          = valid_f ? q_head.pc    : '0;
    pc_plus_4_f   = pc_f + STEP;
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Scoreboard bench for fetch_prefetch with a variable-latency in-order memory model.
module tb_fetch_prefetch;

  localparam int unsigned AW  = 32;
  localparam int unsigned QD  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        valid_f;
  logic [31:0] instruction_f;
  logic [31:0] pc_f;
  logic [31:0] pc_plus_4_f;

  always #5 clk = ~clk;

  fetch_prefetch #(
    .ADDR_WIDTH  (AW),
    .QUEUE_DEPTH (QD),
    .RESET_PC    (RPC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_f        (stall_f),
    .pc_src_e       (pc_src_e),
    .pc_target_e    (pc_target_e),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .valid_f        (valid_f),
    .instruction_f  (instruction_f),
    .pc_f           (pc_f),
    .pc_plus_4_f    (pc_plus_4_f)
  );

  typedef struct { logic [31:0] addr; int unsigned due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } sb_t;

  pend_t       pending[$];
  sb_t         sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned last_due = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  bit          rnd_ready = 1'b0;
  logic [31:0] exp_req = RPC;

  logic        o_rv;
  logic [31:0] o_ra;
  logic        o_vf;
  logic [31:0] o_ins;
  logic [31:0] o_pc;
  logic [31:0] o_pc4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs at negedge, sample #1 later, update models.
  task automatic cycle(input logic rst, input logic stl, input logic redir, input logic [31:0] tgt);
    sb_t         e;
    pend_t       p;
    int unsigned lat;
    reset          = rst;
    stall_f        = stl;
    pc_src_e       = redir;
    pc_target_e    = tgt;
    imem_req_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (rst) begin
      pending.delete();
      last_due = cyc;
    end
    if (pending.size() != 0 && pending[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pending[0].addr);
      void'(pending.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    o_rv = imem_req_valid; o_ra = imem_req_addr; o_vf = valid_f;
    o_ins = instruction_f; o_pc = pc_f; o_pc4 = pc_plus_4_f;
    if (rst) begin
      sb.delete();
      exp_req = RPC;
    end else if (redir) begin
      check_eq("redir_no_req", 32'(o_rv), 32'd0);
      sb.delete();
      exp_req = {tgt[31:2], 2'b00};
    end else begin
      if (o_vf && !stl) begin
        check_eq("deq_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq("pc_f", o_pc, e.pc);
          check_eq("instruction_f", o_ins, e.instr);
          check_eq("pc_plus_4_f", o_pc4, e.pc + 32'd4);
        end
      end
      if (o_rv && imem_req_ready) begin
        check_eq("req_addr", o_ra, exp_req);
        sb.push_back('{pc: exp_req, instr: mem_word(exp_req)});
        lat   = $urandom_range(lat_max, lat_min);
        p.addr = o_ra;
        p.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        last_due = p.due;
        pending.push_back(p);
        exp_req += 32'd4;
      end
    end
    if (!o_vf) check_eq("idle_zero", o_ins | o_pc, 32'd0);
    check_eq("credit_bound", 32'(sb.size() <= QD), 32'd1);
    @(negedge clk);
    cyc++;
  endtask

  logic [31:0] held_pc;
  bit          found;

  initial begin
    reset = 1'b1; stall_f = 1'b0; pc_src_e = 1'b0; pc_target_e = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    @(negedge clk);

    // Reset values and streaming start-up with a zero-wait memory.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, '0);
    check_eq("rst_req_valid", 32'(o_rv), 32'd0);
    check_eq("rst_valid_f", 32'(o_vf), 32'd0);
    check_eq("rst_instr", o_ins, 32'd0);
    check_eq("rst_pc_f", o_pc, 32'd0);
    check_eq("rst_pc4", o_pc4, 32'd4);
    check_eq("rst_req_addr", o_ra, RPC);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check_eq("first_req_valid", 32'(o_rv), 32'd1);
    check_eq("first_req_addr", o_ra, RPC);
    check_eq("first_valid_low", 32'(o_vf), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check_eq("second_valid_low", 32'(o_vf), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check_eq("startup_valid", 32'(o_vf), 32'd1);
    check_eq("startup_pc", o_pc, RPC);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 1'b0, '0);
      check_eq("throughput_valid", 32'(o_vf), 32'd1);
    end

    // Stall: queue fills to depth, requests stop, head holds.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 1'b0, '0);
      if (i == 0) held_pc = o_pc;
      else check_eq("stall_head_stable", o_pc, held_pc);
    end
    check_eq("stall_req_low", 32'(o_rv), 32'd0);
    check_eq("stall_full", 32'(sb.size()), QD);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, '0);
      check_eq("drain_valid", 32'(o_vf), 32'd1);
    end

    // Redirect with two live requests on a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    repeat (2) cycle(1'b1, 1'b0, 1'b0, '0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b0, 1'b0, 1'b0, '0);
      if (o_vf) found = 1'b1;
    end
    check_eq("redir_target_arrived", 32'(found), 32'd1);
    check_eq("redir_first_pc", o_pc, 32'h0000_0100);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check_eq("redir_second_valid", 32'(o_vf), 32'd1);
    check_eq("redir_second_pc", o_pc, 32'h0000_0104);

    // Redirect to an unaligned target while a response lands in the same cycle.
    lat_min = 1; lat_max = 1;
    repeat (6) cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0203);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check_eq("unaligned_req_valid", 32'(o_rv), 32'd1);
    check_eq("unaligned_req_addr", o_ra, 32'h0000_0200);
    check_eq("unaligned_queue_empty", 32'(o_vf), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check_eq("unaligned_still_empty", 32'(o_vf), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check_eq("unaligned_target_valid", 32'(o_vf), 32'd1);
    check_eq("unaligned_target_pc", o_pc, 32'h0000_0200);

    // Random ready, latency, stalls and redirects.
    rnd_ready = 1'b1; lat_min = 1; lat_max = 5;
    for (int i = 0; i < 800; i++) begin
      cycle(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
            $urandom & 32'h0000_FFFF);
    end

    // Reset mid-stream with a full queue.
    rnd_ready = 1'b0; lat_min = 1; lat_max = 1;
    repeat (8) cycle(1'b0, 1'b0, 1'b0, '0);
    repeat (8) cycle(1'b0, 1'b1, 1'b0, '0);
    check_eq("full_before_reset", 32'(sb.size()), QD);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check_eq("post_reset_valid_f", 32'(o_vf), 32'd0);
    check_eq("post_reset_req_addr", o_ra, RPC);
    check_eq("post_reset_req_valid", 32'(o_rv), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check_eq("post_reset_first_pc", o_pc, RPC);
    check_eq("post_reset_first_valid", 32'(o_vf), 32'd1);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised instruction-fetch stage that replaces the single-cycle combinational-memory fetch with a decoupled, latency-tolerant front end. It issues in-order requests to an instruction memory over a valid/ready request channel and accepts in-order responses, buffering fetched instructions in a prefetch queue ahead of decode. Branch redirects from execute flush the queue and discard any responses still in flight. It sits between the instruction memory/cache and the decode pipeline register.

## Interface
- ADDR_WIDTH, 32, width of PC and memory address
- QUEUE_DEPTH, 4, prefetch queue entries; power of two, ≥2
- RESET_PC, '0, first fetch address after reset
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- stall_f  in  1  decode not accepting; hold queue head
- pc_src_e  in  1  redirect request from execute
- pc_target_e  in  ADDR_WIDTH  redirect target; bits [1:0] ignored (treated as 0)
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_WIDTH  word-aligned fetch address
- imem_rsp_valid  in  1  response valid; in order, no backpressure
- imem_rsp_data  in  32  instruction word
- valid_f  out  1  queue head holds a valid instruction
- instruction_f  out  32  head instruction; 0 when !valid_f
- pc_f  out  ADDR_WIDTH  head PC; 0 when !valid_f
- pc_plus_4_f  out  ADDR_WIDTH  pc_f + 4, modulo 2^ADDR_WIDTH

## Operation
- State: fetch_pc (next address to request), rsp_pc (PC of next live response), queue count, live (outstanding live requests), drop (outstanding stale requests).
- Issue: imem_req_valid = !reset && !pc_src_e && (count + live < QUEUE_DEPTH) && (live + drop < QUEUE_DEPTH). imem_req_addr = fetch_pc. On handshake: fetch_pc += 4, live += 1.
- Credit rule guarantees every live response has a free queue slot; queue can never overflow.
- Response: if drop > 0, response is discarded, drop -= 1. Otherwise enqueue {rsp_pc, imem_rsp_data}, rsp_pc += 4, live -= 1.
- Dequeue: when valid_f && !stall_f && !pc_src_e; head advances.
- Redirect (pc_src_e = 1): queue cleared; fetch_pc and rsp_pc <= {pc_target_e[ADDR_WIDTH-1:2], 2'b00}; drop <= drop + live − (stale response this cycle ? 1 : 0), i.e. every outstanding request becomes stale; live <= 0. No request issued in the redirect cycle. Response arriving in the redirect cycle is discarded regardless of drop.
- Simultaneous enqueue and dequeue: both occur; count unchanged. Dequeue from empty never occurs.
- Reset: fetch_pc = rsp_pc = RESET_PC, count = live = drop = 0. Memory is reset by the same reset and returns no responses for pre-reset requests. Reset mid-operation discards all queue contents.

## Timing
- Reset outputs: imem_req_valid 0, valid_f 0, instruction_f 0, pc_f 0, pc_plus_4_f 4, imem_req_addr RESET_PC.
- First request: cycle after reset deasserts.
- Response-to-valid_f: response in cycle N → valid_f in N+1 (registered queue, no bypass).
- Zero-wait memory (ready=1, response 1 cycle after accept): steady-state throughput one instruction/cycle after 2-cycle start-up.
- Redirect in cycle R: valid_f 0 in R+1; target request issued in R+1; target instruction earliest valid in R+3.
- imem_req_valid depends combinationally on pc_src_e only; all other outputs are registered or derived from registered state.
- stall_f holds head outputs stable; issuing continues until credits are exhausted.

## Structure
- Shared package fetch_pkg: fetch_entry_t {pc, instr}, INSTR_BYTES = 4, helper for counter width $clog2(QUEUE_DEPTH+1).
- Sub-module fetch_queue: circular FIFO of fetch_entry_t with push, pop, synchronous flush, count; pointers wrap modulo QUEUE_DEPTH.
- Top holds PC registers, live/drop counters, issue logic.

## Test plan
- Reset, ready=1, 1-cycle memory returning addr-based words -> pc_f sequence 0,4,8,12… one per cycle; valid_f rises 2 cycles after first request.
- stall_f held 10 cycles, QUEUE_DEPTH=4 -> exactly 4 entries queued, imem_req_valid low, head stable; release -> 4 entries drain in order, no gaps/duplicates.
- 3-cycle memory latency, redirect to 0x100 with 2 live requests -> both stale responses dropped, next valid_f shows pc_f 0x100, then 0x104.
- Redirect with pc_target_e 0x203 and response arriving same cycle -> response discarded, request addr 0x200, queue empty next cycle.
- Random imem_req_ready and latency 1–5, random redirects -> scoreboard: every delivered (pc, instr) matches memory model; count never exceeds QUEUE_DEPTH.
- Reset asserted mid-stream with full queue -> next cycle valid_f 0, imem_req_addr RESET_PC, fetch resumes from RESET_PC.
